// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter family: count mode, MAX
// derivation and load clamping.
package counter_pkg;

  // Behaviour at the ends of the count range.
  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } count_mode_e;

  // Largest legal count value for a given modulus.
  function automatic longint unsigned max_of(input longint unsigned modulus);
    return modulus - 64'd1;
  endfunction

  // Clamp a load value into 0..max; out-of-range loads land on max.
  function automatic logic [63:0] clamp_load(input logic [63:0] value,
                                             input logic [63:0] max);
    logic [63:0] result;
    if (value > max) begin
      result = max;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count logic: step up/down within 0..MAX, flag the
// wrap/saturate event and produce the terminal-count indication.
module mod_counter_next
  import counter_pkg::*;
#(
  parameter int          WIDTH = 4,
  parameter count_mode_e MODE  = CNT_WRAP
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             up_i,
  input  logic             en_i,
  input  logic [WIDTH:0]   max_i,
  output logic [WIDTH-1:0] q_next_o,
  output logic             wrap_o,
  output logic             tc_o
);

  // One extra bit so neither the increment nor the decrement can lose
  // information: the carry/borrow is what detects the range ends.
  logic [WIDTH:0] q_ext_s;
  logic [WIDTH:0] inc_ext_s;
  logic [WIDTH:0] dec_ext_s;
  logic           at_max_s;
  logic           at_zero_s;

  assign q_ext_s   = {1'b0, q_i};
  assign inc_ext_s = q_ext_s + {{WIDTH{1'b0}}, 1'b1};
  assign dec_ext_s = q_ext_s - {{WIDTH{1'b0}}, 1'b1};
  // q+1 beyond MAX means q is at the top of the range.
  assign at_max_s  = (inc_ext_s > max_i);
  // A borrow out of q-1 means q is zero.
  assign at_zero_s = dec_ext_s[WIDTH];

  assign tc_o = en_i & ((up_i & at_max_s) | (~up_i & at_zero_s));

  // Next count and range-end event for the enabled step.
  always_comb begin
    q_next_o = q_i;
    wrap_o   = 1'b0;
    if (!en_i) begin
      q_next_o = q_i;
      wrap_o   = 1'b0;
    end else if (up_i) begin
      if (at_max_s) begin
        wrap_o = 1'b1;
        if (MODE == CNT_SAT) begin
          q_next_o = q_i;
        end else begin
          q_next_o = {WIDTH{1'b0}};
        end
      end else begin
        q_next_o = inc_ext_s[WIDTH-1:0];
      end
    end else begin
      if (at_zero_s) begin
        wrap_o = 1'b1;
        if (MODE == CNT_SAT) begin
          q_next_o = q_i;
        end else begin
          q_next_o = max_i[WIDTH-1:0];
        end
      end else begin
        q_next_o = dec_ext_s[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo counter: programmable width and modulus, up/down,
// synchronous clear/load, enable, wrap or saturate, tc and ovf flags.
module mod_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int              SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam int             MAX_W = WIDTH + 1;
  localparam logic [WIDTH:0] MAX   = MAX_W'(max_of(MODULUS));
  localparam count_mode_e    MODE  = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             ovf_q;
  logic             ovf_d;
  logic [WIDTH-1:0] q_next_s;
  logic             wrap_s;
  logic             tc_s;

  mod_counter_next #(
    .WIDTH (WIDTH),
    .MODE  (MODE)
  ) u_next (
    .q_i      (q_q),
    .up_i     (up),
    .en_i     (en),
    .max_i    (MAX),
    .q_next_o (q_next_s),
    .wrap_o   (wrap_s),
    .tc_o     (tc_s)
  );

  // Control priority: clear, then load, then enabled count, else hold.
  always_comb begin
    q_d   = q_q;
    ovf_d = 1'b0;
    if (clr) begin
      q_d   = {WIDTH{1'b0}};
      ovf_d = 1'b0;
    end else if (load) begin
      q_d   = WIDTH'(clamp_load(64'(load_val), 64'(MAX)));
      ovf_d = 1'b0;
    end else if (en) begin
      q_d   = q_next_s;
      ovf_d = wrap_s;
    end else begin
      q_d   = q_q;
      ovf_d = 1'b0;
    end
  end

  // Count and overflow-pulse registers; reset drops any pending pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q   <= {WIDTH{1'b0}};
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign ovf = ovf_q;
  assign tc  = tc_s;

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: four configurations driven in
// lockstep, checked against a behavioural model plus directed expectations.
module tb_mod_counter;

  logic        clk;
  logic        reset_n;
  logic        clr;
  logic        load;
  logic        en;
  logic        up;
  logic [11:0] lv;
  logic [3:0]  lv4;
  logic [3:0]  q0, q1, q2;
  logic [11:0] q3;
  logic        tc0, tc1, tc2, tc3;
  logic        ovf0, ovf1, ovf2, ovf3;

  assign lv4 = lv[3:0];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one entry per DUT.
  int maxv[4] = '{15, 9, 9, 4095};
  bit satv[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  int mq[4]   = '{0, 0, 0, 0};
  bit mo[4]   = '{1'b0, 1'b0, 1'b0, 1'b0};

  mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(lv4),
    .en(en), .up(up), .q(q0), .tc(tc0), .ovf(ovf0));
  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u1 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(lv4),
    .en(en), .up(up), .q(q1), .tc(tc1), .ovf(ovf1));
  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u2 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(lv4),
    .en(en), .up(up), .q(q2), .tc(tc2), .ovf(ovf2));
  mod_counter #(.WIDTH(12), .MODULUS(4096), .SATURATE(0)) u3 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(lv),
    .en(en), .up(up), .q(q3), .tc(tc3), .ovf(ovf3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dq(input int i);
    case (i)
      0: return int'(q0);
      1: return int'(q1);
      2: return int'(q2);
      3: return int'(q3);
      default: return -1;
    endcase
  endfunction

  function automatic int dtc(input int i);
    case (i)
      0: return int'(tc0);
      1: return int'(tc1);
      2: return int'(tc2);
      3: return int'(tc3);
      default: return -1;
    endcase
  endfunction

  function automatic int dovf(input int i);
    case (i)
      0: return int'(ovf0);
      1: return int'(ovf1);
      2: return int'(ovf2);
      3: return int'(ovf3);
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Terminal count as defined from the counting rules.
  function automatic int model_tc(input int i);
    if (!en) return 0;
    if (up) return (mq[i] == maxv[i]) ? 1 : 0;
    return (mq[i] == 0) ? 1 : 0;
  endfunction

  // Apply one clock edge of the counting rules to every model entry.
  task automatic model_edge();
    int v;
    for (int i = 0; i < 4; i++) begin
      if (reset_n) begin
        v = (i == 3) ? int'(lv) : int'(lv[3:0]);
        if (clr) begin
          mq[i] = 0; mo[i] = 1'b0;
        end else if (load) begin
          mq[i] = (v > maxv[i]) ? maxv[i] : v; mo[i] = 1'b0;
        end else if (en) begin
          if (up) begin
            if (mq[i] == maxv[i]) begin
              mo[i] = 1'b1; mq[i] = satv[i] ? maxv[i] : 0;
            end else begin
              mo[i] = 1'b0; mq[i] = mq[i] + 1;
            end
          end else begin
            if (mq[i] == 0) begin
              mo[i] = 1'b1; mq[i] = satv[i] ? 0 : maxv[i];
            end else begin
              mo[i] = 1'b0; mq[i] = mq[i] - 1;
            end
          end
        end else begin
          mo[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit c, input bit l, input bit e,
                       input bit u, input int v);
    reset_n = r; clr = c; load = l; en = e; up = u; lv = 12'(v);
    if (!r) begin
      for (int i = 0; i < 4; i++) begin
        mq[i] = 0; mo[i] = 1'b0;
      end
    end
  endtask

  // One cycle from a falling edge: tc check, edge, q/ovf checks.
  task automatic cycle();
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("tc[%0d]", i), dtc(i), model_tc(i));
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("q[%0d]", i), dq(i), mq[i]);
      chk($sformatf("ovf[%0d]", i), dovf(i), int'(mo[i]));
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit c; bit l; bit e; bit u; int v; int exp_q; int exp_ovf;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // Directed vectors for the modulo-10 wrapping counter (u1).
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0,  0, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7,  7, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 13, 9, 0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5,  0, 0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 5,  5, 0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0,  6, 0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0,  6, 0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 9,  9, 0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0,  0, 1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0,  9, 1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 0,  8, 0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 15, 9, 0};

    // Reset state, and tc following en & !up while in reset.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_q[%0d]", i), dq(i), 0);
      chk($sformatf("rst_ovf[%0d]", i), dovf(i), 0);
      chk($sformatf("rst_tc_down[%0d]", i), dtc(i), 1);
    end
    up = 1'b1;
    #1;
    chk("rst_tc_up", int'(tc0), 0);

    // Count to 5, then reset asynchronously between edges.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    for (int k = 0; k < 5; k++) cycle();
    chk("count_to_5", int'(q0), 5);
    #2;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    #1;
    chk("async_rst_q", int'(q0), 0);
    @(negedge clk);
    chk("rst_held_q", int'(q0), 0);

    // Full 0..15 wrap of the 4-bit counter.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("w16_tc", int'(tc0), (k == 15) ? 1 : 0);
      cycle();
      chk("w16_q", int'(q0), (k + 1) % 16);
      chk("w16_ovf", int'(ovf0), (k == 15) ? 1 : 0);
    end

    // Modulo-10 up wrap and down wrap.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7);
    cycle();
    chk("m10_load7", int'(q1), 7);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    cycle();
    chk("m10_q8", int'(q1), 8);
    cycle();
    chk("m10_q9", int'(q1), 9);
    cycle();
    chk("m10_wrap_q", int'(q1), 0);
    chk("m10_wrap_ovf", int'(ovf1), 1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    cycle();
    chk("m10_down_q", int'(q1), 9);
    chk("m10_down_ovf", int'(ovf1), 1);

    // Saturating counter held up for 12 enabled edges from zero.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    for (int k = 1; k <= 12; k++) begin
      #1;
      chk("sat_tc", int'(tc2), (k >= 10) ? 1 : 0);
      cycle();
      chk("sat_q", int'(q2), (k < 9) ? k : 9);
      chk("sat_ovf", int'(ovf2), (k >= 10) ? 1 : 0);
    end

    // Load clamp and priority vectors.
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, vecs[k].c, vecs[k].l, vecs[k].e, vecs[k].u, vecs[k].v);
      cycle();
      chk($sformatf("vec%0d_q", k), int'(q1), vecs[k].exp_q);
      chk($sformatf("vec%0d_ovf", k), int'(ovf1), vecs[k].exp_ovf);
    end

    // Enable gating with direction toggling on each enabled edge.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3);
    cycle();
    begin
      int exp_seq[6] = '{4, 4, 3, 3, 4, 4};
      bit dir = 1'b1;
      for (int k = 0; k < 6; k++) begin
        drive(1'b1, 1'b0, 1'b0, (k % 2 == 0), dir, 0);
        #1;
        chk("gate_tc", int'(tc1), 0);
        cycle();
        chk("gate_q", int'(q1), exp_seq[k]);
        if (k % 2 == 0) dir = ~dir;
      end
    end

    // Wide counter: natural binary wrap from 4095.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4095);
    cycle();
    chk("wide_load", int'(q3), 4095);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    #1;
    chk("wide_tc", int'(tc3), 1);
    cycle();
    chk("wide_wrap_q", int'(q3), 0);
    chk("wide_wrap_ovf", int'(ovf3), 1);

    // Random run against the model, with occasional resets.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 31) != 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0),
            $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 4095)));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
